// File: rtl/alarm_timebase_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type, BCD limits and load-validation helper for the alarm timebase.
package alarm_timebase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;

  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

  // With both digits at most 9, a raw byte compare against a BCD limit is exact.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max_val);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max_val);
  endfunction

endpackage

// File: rtl/alarm_timebase_bcd_mod_counter.sv
`timescale 1ns/1ps
// Two-digit BCD counter wrapping at MAX_VAL, with synchronous load and a carry-out for chaining.
module bcd_mod_counter
  import alarm_timebase_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = BCD_MAX_MIN
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  output logic [7:0] value_o,
  output logic       carry_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_data_i;
    end else if (inc_i) begin
      if (value_q == MAX_VAL) begin
        value_d = '0;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_i && !load_i && (value_q == MAX_VAL);

endmodule

// File: rtl/alarm_timebase.sv
`timescale 1ns/1ps
// Tick-to-seconds prescaler, 24-hour BCD time of day, alarm registers and ring/snooze FSM.
module alarm_timebase
  import alarm_timebase_pkg::*;
#(
  parameter int unsigned TICKS_PER_SECOND = 1000,
  parameter int unsigned PRESCALE_BITS    = 10,
  parameter int unsigned SNOOZE_SECONDS   = 300,
  parameter int unsigned RING_SECONDS     = 60
) (
  input  logic       FPGAClock,
  input  logic       reset,
  input  logic       FPGATick,
  input  logic       time_load,
  input  logic       alarm_load,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       alarm_ring,
  output logic       load_err
);

  localparam int unsigned TIMER_MAX = (SNOOZE_SECONDS > RING_SECONDS) ? SNOOZE_SECONDS : RING_SECONDS;
  localparam int unsigned TW        = $clog2(TIMER_MAX + 1);

  localparam logic [PRESCALE_BITS-1:0] PRESC_LAST  = PRESCALE_BITS'(TICKS_PER_SECOND - 1);
  localparam logic [TW-1:0]            RING_LOAD   = TW'(RING_SECONDS);
  localparam logic [TW-1:0]            SNOOZE_LOAD = TW'(SNOOZE_SECONDS);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic [7:0]               alarm_hour_q, alarm_min_q;
  logic                     sec_pulse_q, load_err_q, alarm_ring_q;
  alarm_state_e             state_q;
  logic [TW-1:0]            ring_t_q, snz_t_q;

  logic time_ok, alarm_ok, sec_adv, match;
  logic sec_carry, min_carry, hr_carry_unused;

  assign time_ok  = time_load  && bcd_valid(load_hour, BCD_MAX_HOUR) && bcd_valid(load_min, BCD_MAX_MIN);
  assign alarm_ok = alarm_load && bcd_valid(load_hour, BCD_MAX_HOUR) && bcd_valid(load_min, BCD_MAX_MIN);

  always_comb begin
    presc_d = presc_q;
    sec_adv = 1'b0;
    if (time_ok) begin
      presc_d = '0;
    end else if (FPGATick) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        sec_adv = 1'b1;
      end else begin
        presc_d = presc_q + PRESCALE_BITS'(1);
      end
    end
  end

  bcd_mod_counter #(.MAX_VAL(BCD_MAX_MIN)) u_sec (
    .clk_i       (FPGAClock),
    .rst_i       (reset),
    .inc_i       (sec_adv),
    .load_i      (time_ok),
    .load_data_i (8'h00),
    .value_o     (seconds),
    .carry_o     (sec_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_MAX_MIN)) u_min (
    .clk_i       (FPGAClock),
    .rst_i       (reset),
    .inc_i       (sec_carry),
    .load_i      (time_ok),
    .load_data_i (load_min),
    .value_o     (minutes),
    .carry_o     (min_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_MAX_HOUR)) u_hour (
    .clk_i       (FPGAClock),
    .rst_i       (reset),
    .inc_i       (min_carry),
    .load_i      (time_ok),
    .load_data_i (load_hour),
    .value_o     (hours),
    .carry_o     (hr_carry_unused)
  );

  always_ff @(posedge FPGAClock or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      sec_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
    end else begin
      presc_q     <= presc_d;
      sec_pulse_q <= sec_adv;
      load_err_q  <= (time_load && !time_ok) || (alarm_load && !alarm_ok);
      if (alarm_ok) begin
        alarm_hour_q <= load_hour;
        alarm_min_q  <= load_min;
      end
    end
  end

  // Match is judged on the registered time during the sec_pulse cycle, so the ring
  // rises one cycle after the outputs show the alarm time; timers step on the same strobe.
  assign match = sec_pulse_q && (seconds == 8'h00) &&
                 (minutes == alarm_min_q) && (hours == alarm_hour_q);

  always_ff @(posedge FPGAClock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ring_t_q     <= '0;
      snz_t_q      <= '0;
      alarm_ring_q <= 1'b0;
    end else if (!alarm_en) begin
      state_q      <= ST_IDLE;
      alarm_ring_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_q      <= ST_RINGING;
            ring_t_q     <= RING_LOAD;
            alarm_ring_q <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state_q      <= ST_IDLE;
            alarm_ring_q <= 1'b0;
          end else if (snooze) begin
            state_q      <= ST_SNOOZE;
            snz_t_q      <= SNOOZE_LOAD;
            alarm_ring_q <= 1'b0;
          end else if (sec_pulse_q) begin
            if (ring_t_q <= TW'(1)) begin
              state_q      <= ST_IDLE;
              ring_t_q     <= '0;
              alarm_ring_q <= 1'b0;
            end else begin
              ring_t_q <= ring_t_q - TW'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (sec_pulse_q) begin
            if (snz_t_q <= TW'(1)) begin
              state_q      <= ST_RINGING;
              snz_t_q      <= '0;
              ring_t_q     <= RING_LOAD;
              alarm_ring_q <= 1'b1;
            end else begin
              snz_t_q <= snz_t_q - TW'(1);
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          alarm_ring_q <= 1'b0;
        end
      endcase
    end
  end

  assign sec_pulse  = sec_pulse_q;
  assign load_err   = load_err_q;
  assign alarm_ring = alarm_ring_q;

endmodule

// File: tb/tb_alarm_timebase.sv
`timescale 1ns/1ps
// Directed and randomised checks of alarm_timebase against a seconds-of-day reference model.
module tb_alarm_timebase;

  localparam int TPS  = 4;
  localparam int SNZ  = 3;
  localparam int RING = 5;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0, tl = 1'b0, al = 1'b0, en = 1'b0, st = 1'b0, sn = 1'b0;
  logic [7:0] lh = 8'h00, lm = 8'h00;
  logic [7:0] hours, minutes, seconds;
  logic       sec_pulse, alarm_ring, load_err;

  alarm_timebase #(
    .TICKS_PER_SECOND (TPS),
    .PRESCALE_BITS    (3),
    .SNOOZE_SECONDS   (SNZ),
    .RING_SECONDS     (RING)
  ) dut (
    .FPGAClock  (clk),
    .reset      (rst),
    .FPGATick   (tick),
    .time_load  (tl),
    .alarm_load (al),
    .load_hour  (lh),
    .load_min   (lm),
    .alarm_en   (en),
    .stop       (st),
    .snooze     (sn),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .sec_pulse  (sec_pulse),
    .alarm_ring (alarm_ring),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: time as seconds since midnight, alarm as minute of day, mode 0/1/2 = idle/ringing/snoozed.
  int m_tod, m_ticks, m_alarm, m_mode, m_ring_left, m_snz_left;
  bit m_pulse, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int bcd_to_int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_to_int(v) <= lim);
  endfunction

  task automatic model_reset();
    m_tod = 0; m_ticks = 0; m_alarm = 0; m_mode = 0;
    m_ring_left = 0; m_snz_left = 0; m_pulse = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int o_tod   = m_tod;
    bit o_pulse = m_pulse;
    bit tv = bcd_ok(lh, 23) && bcd_ok(lm, 59);
    if (!en) m_mode = 0;
    else begin
      case (m_mode)
        0: if (o_pulse && o_tod == m_alarm * 60) begin m_mode = 1; m_ring_left = RING; end
        1: begin
          if (st) m_mode = 0;
          else if (sn) begin m_mode = 2; m_snz_left = SNZ; end
          else if (o_pulse) begin
            m_ring_left--;
            if (m_ring_left == 0) m_mode = 0;
          end
        end
        default: begin
          if (st) m_mode = 0;
          else if (o_pulse) begin
            m_snz_left--;
            if (m_snz_left == 0) begin m_mode = 1; m_ring_left = RING; end
          end
        end
      endcase
    end
    m_err = (tl && !tv) || (al && !tv);
    if (al && tv) m_alarm = bcd_to_int(lh) * 60 + bcd_to_int(lm);
    m_pulse = 0;
    if (tl && tv) begin
      m_tod   = bcd_to_int(lh) * 3600 + bcd_to_int(lm) * 60;
      m_ticks = 0;
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == TPS) begin
        m_ticks = 0;
        m_tod   = (m_tod + 1) % 86400;
        m_pulse = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("hours",      hours,      to_bcd(m_tod / 3600));
    check("minutes",    minutes,    to_bcd((m_tod / 60) % 60));
    check("seconds",    seconds,    to_bcd(m_tod % 60));
    check("sec_pulse",  sec_pulse,  m_pulse);
    check("alarm_ring", alarm_ring, m_mode == 1);
    check("load_err",   load_err,   m_err);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    cyc_n++;
    compare_all();
  endtask

  task automatic drive(input bit t, input bit tload, input bit aload, input bit stp, input bit snz);
    tick = t; tl = tload; al = aload; st = stp; sn = snz;
    step();
    tick = 0; tl = 0; al = 0; st = 0; sn = 0;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0);
      for (int g = 1; g < gap; g++) drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic wait_ring(input string tag);
    for (int i = 0; i < 600 && !alarm_ring; i++) drive(1, 0, 0, 0, 0);
    check(tag, alarm_ring, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int pc, t_show, t_rise, t_fall, np, lp, rc;
    logic [7:0] hv [5];
    logic [7:0] mv [4];
    hv = '{8'h07, 8'h06, 8'h23, 8'h24, 8'h1A};
    mv = '{8'h59, 8'h00, 8'h5A, 8'h3B};
    model_reset();

    repeat (3) step();
    check("rst_time", {8'h00, hours, minutes, seconds}, 32'h0);
    check("rst_ring", alarm_ring, 1'b0);
    check("rst_pulse", sec_pulse, 1'b0);
    rst = 1'b0;
    step();

    pc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      if (sec_pulse) pc++;
      repeat (2) begin drive(0, 0, 0, 0, 0); if (sec_pulse) pc++; end
    end
    check("prescale_pulses", pc, 1);
    check("prescale_sec", seconds, 8'h01);

    lh = 8'h23; lm = 8'h59;
    drive(0, 1, 0, 0, 0);
    check("load_time", {8'h00, hours, minutes, seconds}, 32'h00235900);
    run_ticks(236, 1);
    check("pre_rollover", {8'h00, hours, minutes, seconds}, 32'h00235959);
    run_ticks(4, 1);
    check("rollover", {8'h00, hours, minutes, seconds}, 32'h0);

    lh = 8'h24; lm = 8'h00;
    drive(0, 1, 0, 0, 0);
    check("err_hour", load_err, 1'b1);
    check("err_hour_time", {8'h00, hours, minutes, seconds}, 32'h0);
    drive(0, 0, 0, 0, 0);
    check("err_clear", load_err, 1'b0);
    lh = 8'h10; lm = 8'h5A;
    drive(0, 1, 0, 0, 0);
    check("err_min", load_err, 1'b1);
    check("err_min_time", {8'h00, hours, minutes, seconds}, 32'h0);
    lh = 8'h1A; lm = 8'h00;
    drive(0, 0, 1, 0, 0);
    check("err_alarm", load_err, 1'b1);
    lh = 8'h12; lm = 8'h30;
    drive(0, 1, 1, 0, 0);
    check("both_ok_err", load_err, 1'b0);
    check("both_ok_time", {8'h00, hours, minutes, seconds}, 32'h00123000);

    en = 1'b1;
    lh = 8'h06; lm = 8'h59; drive(0, 1, 0, 0, 0);
    lh = 8'h07; lm = 8'h00; drive(0, 0, 1, 0, 0);
    t_show = -1; t_rise = -1; t_fall = -1;
    for (int i = 0; i < 270; i++) begin
      drive(1, 0, 0, 0, 0);
      if (t_show < 0 && {hours, minutes, seconds} == 24'h070000) t_show = cyc_n;
      if (t_rise < 0 && alarm_ring) t_rise = cyc_n;
      if (t_rise >= 0 && t_fall < 0 && !alarm_ring) t_fall = cyc_n;
    end
    check("ring_seen", t_rise >= 0, 1'b1);
    check("ring_latency", 32'(t_rise - t_show), 32'd1);
    check("ring_len", 32'(t_fall - t_rise), 32'(RING * TPS));

    lh = 8'h08; lm = 8'h00; drive(0, 0, 1, 0, 0);
    lh = 8'h07; lm = 8'h59; drive(0, 1, 0, 0, 0);
    wait_ring("snz_ring_seen");
    drive(0, 0, 0, 0, 1);
    check("snz_drop", alarm_ring, 1'b0);
    np = 0; lp = -100;
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 0, 0, 0);
      if (alarm_ring) break;
      if (sec_pulse) begin np++; lp = cyc_n; end
    end
    check("snz_rering", alarm_ring, 1'b1);
    check("snz_seconds", np, SNZ);
    check("snz_edge", 32'(cyc_n - lp), 32'd1);
    drive(0, 0, 0, 1, 1);
    check("stop_snz_drop", alarm_ring, 1'b0);
    rc = 0;
    for (int i = 0; i < 6 * TPS; i++) begin
      drive(1, 0, 0, 0, 0);
      if (alarm_ring) rc++;
    end
    check("stop_snz_idle", rc, 0);

    lh = 8'h07; lm = 8'h59; drive(0, 1, 0, 0, 0);
    wait_ring("rst_ring_seen");
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_ring", alarm_ring, 1'b0);
    check("rst_mid_time", {8'h00, hours, minutes, seconds}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      bit t, tload, aload, stp, snz;
      t     = 1'($urandom_range(0, 1));
      tload = $urandom_range(0, 999) < 2;
      aload = $urandom_range(0, 999) < 3;
      stp   = $urandom_range(0, 199) == 0;
      snz   = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 499) == 0) en = ~en;
      if (tload || aload) begin
        lh = hv[$urandom_range(0, 4)];
        lm = mv[$urandom_range(0, 3)];
      end
      drive(t, tload, aload, stp, snz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
